seven_seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for the 4-digit seven-segment display driver.
//  - Rotates a one-hot digit select (digit 0..3) at a fixed refresh rate.
//  - Presents the matching BCD nibble with each select.
//  - Inserts an all-off blanking gap between digits to suppress ghosting.
//  - Accepts new display values over a valid/ready handshake and applies them only at frame start, so a frame never mixes old and new digits.

---
 rtl/seven_seg_scan_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading-zero digits).
module seven_seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    output logic [3:0]  digit_sel,
    output logic [3:0]  bcd_out,
    output logic        frame_done
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [15:0]   active, active_n;
    logic [15:0]   pending, pending_n;
    logic          ready_n;
    logic [3:0]    digit_sel_n;
    logic [3:0]    bcd_n;
    logic          frame_done_n;
    logic          lit;
    logic          cnt_last;

    assign cnt_last = (cnt == CW'(1));

    // State, counter, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= 2'd0;
            active      <= 16'd0;
            pending     <= 16'd0;
            value_ready <= 1'b1;
            digit_sel   <= 4'd0;
            bcd_out     <= 4'd0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            active      <= active_n;
            pending     <= pending_n;
            value_ready <= ready_n;
            digit_sel   <= digit_sel_n;
            bcd_out     <= bcd_n;
            frame_done  <= frame_done_n;
        end
    end

    // Next-state: IDLE -> BLANK -> SHOW -> BLANK ..., enable low aborts to IDLE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = BLANK;
                    cnt_n   = CW'(BLANK_CYCLES);
                    idx_n   = 2'd0;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                end else if (cnt_last) begin
                    state_n = SHOW;
                    cnt_n   = CW'(SCAN_DIV);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                end else if (cnt_last) begin
                    state_n = BLANK;
                    cnt_n   = CW'(BLANK_CYCLES);
                    idx_n   = 2'(idx + 2'd1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = 2'd0;
            end
        endcase
    end

    // Handshake and outputs, decoded from next state so outputs line up with the state register
    always_comb begin
        pending_n    = pending;
        active_n     = active;
        ready_n      = value_ready;
        digit_sel_n  = 4'd0;
        bcd_n        = 4'd0;
        frame_done_n = 1'b0;

        if (value_ready && value_valid) begin
            pending_n = value;
            ready_n   = 1'b0;
        end else if (!value_ready &&
                     (state == IDLE || (state == BLANK && state_n == SHOW && idx == 2'd0))) begin
            active_n = pending;
            ready_n  = 1'b1;
        end

`ifdef LEADING_ZERO_BLANK_EN
        lit = (idx_n == 2'd0) || ((active_n >> {idx_n, 2'b00}) != 16'd0);
`else
        lit = 1'b1;
`endif

        if (state_n == SHOW && lit) begin
            digit_sel_n = 4'b0001 << idx_n;
            bcd_n       = active_n[{idx_n, 2'b00} +: 4];
        end

        frame_done_n = (state == SHOW) && (state_n == BLANK) && (idx == 2'd3);
    end

endmodule
